// File: rtl/zip_pipemem_if.sv
// Wishbone B4 pipelined bus bundle between zip_pipemem (master) and the data-bus slave.
interface zip_pipemem_if #(
  parameter int AW = 30
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [3:0]    sel;
  logic          stall;
  logic          ack;
  logic          err;
  logic [31:0]   rdata;

  modport master (output cyc, stb, we, addr, wdata, sel,
                  input  stall, ack, err, rdata);
  modport slave  (input  cyc, stb, we, addr, wdata, sel,
                  output stall, ack, err, rdata);
endinterface

// File: rtl/zip_pipemem.sv
// Pipelined Wishbone load/store unit for the ZipCPU: issues CPU requests on the bus and
// returns tagged, lane-selected read results in order through a small return-tag FIFO.
module zip_pipemem #(
    parameter int ADDRESS_WIDTH     = 30,
    parameter int LGDEPTH           = 2,
    parameter bit OPT_ALIGNMENT_ERR = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stb,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    input  logic [4:0]  i_oreg,
    output logic        o_busy,
    output logic        o_rdbusy,
    output logic        o_pipe_stalled,
    output logic        o_done,
    output logic        o_valid,
    output logic        o_err,
    output logic [4:0]  o_wreg,
    output logic [31:0] o_result,
    zip_pipemem_if.master wb
);
    localparam int DEPTH = 1 << LGDEPTH;
    localparam logic [LGDEPTH:0] FULL   = (LGDEPTH+1)'(DEPTH);
    localparam logic [LGDEPTH:0] ALMOST = (LGDEPTH+1)'(DEPTH-1);

    logic [LGDEPTH:0]   outstanding, out_next;
    logic [LGDEPTH-1:0] wr_ptr, rd_ptr;
    logic [8:0]         tag_mem [DEPTH];
    logic [8:0]         tag_out;
    logic               misaligned, accept, issue, issued, bus_ack, bus_err;
    logic [3:0]         req_sel;
    logic [31:0]        req_data, rd_lane;

    always_comb begin
        misaligned = OPT_ALIGNMENT_ERR &&
                     (((i_op[2:1] == 2'b01) && (i_addr[1:0] != 2'b00)) ||
                      ((i_op[2:1] == 2'b10) && i_addr[0]));
        // A request still waiting on the bus already owns a FIFO slot, so count it too.
        if (wb.stb)
            o_pipe_stalled = wb.stall || (outstanding == ALMOST);
        else
            o_pipe_stalled = (outstanding == FULL);
        accept  = i_stb && !o_pipe_stalled;
        issue   = accept && !misaligned;
        issued  = wb.stb && !wb.stall;
        bus_ack = wb.ack && wb.cyc;
        bus_err = wb.err && wb.cyc;
        out_next = outstanding;
        if (issued && !bus_ack)
            out_next = outstanding + 1'b1;
        else if (!issued && bus_ack)
            out_next = outstanding - 1'b1;
    end

    // Big-endian lanes: byte offset 0 is bits [31:24].
    always_comb begin
        case (i_op[2:1])
            2'b10:   begin req_sel = i_addr[1] ? 4'b0011 : 4'b1100; req_data = {2{i_data[15:0]}}; end
            2'b11:   begin req_sel = 4'b1000 >> i_addr[1:0];        req_data = {4{i_data[7:0]}};  end
            default: begin req_sel = 4'b1111;                       req_data = i_data;            end
        endcase
    end

    assign tag_out = tag_mem[rd_ptr];

    always_comb begin
        case (tag_out[3:2])
            2'b10:   rd_lane = {16'h0, tag_out[1] ? wb.rdata[15:0] : wb.rdata[31:16]};
            2'b11: begin
                case (tag_out[1:0])
                    2'b00:   rd_lane = {24'h0, wb.rdata[31:24]};
                    2'b01:   rd_lane = {24'h0, wb.rdata[23:16]};
                    2'b10:   rd_lane = {24'h0, wb.rdata[15:8]};
                    default: rd_lane = {24'h0, wb.rdata[7:0]};
                endcase
            end
            default: rd_lane = wb.rdata;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (issue)
            tag_mem[wr_ptr] <= {i_oreg, i_op[2:1], i_addr[1:0]};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wb.cyc      <= 1'b0;
            wb.stb      <= 1'b0;
            wb.we       <= 1'b0;
            wb.addr     <= '0;
            wb.wdata    <= '0;
            wb.sel      <= '0;
            outstanding <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_done      <= 1'b0;
            o_valid     <= 1'b0;
            o_err       <= 1'b0;
            o_wreg      <= '0;
            o_result    <= '0;
        end else begin
            o_done  <= 1'b0;
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            if (bus_err) begin
                wb.cyc      <= 1'b0;
                wb.stb      <= 1'b0;
                outstanding <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                o_err       <= 1'b1;
            end else begin
                outstanding <= out_next;
                if (issued)
                    wb.stb <= 1'b0;
                if (!issue && !(wb.stb && wb.stall) && (out_next == '0))
                    wb.cyc <= 1'b0;
                if (issue) begin
                    wb.cyc   <= 1'b1;
                    wb.stb   <= 1'b1;
                    wb.we    <= i_op[0];
                    wb.addr  <= i_addr[ADDRESS_WIDTH+1:2];
                    wb.sel   <= req_sel;
                    wb.wdata <= req_data;
                    wr_ptr   <= wr_ptr + 1'b1;
                end
                if (accept && misaligned)
                    o_err <= 1'b1;
                if (bus_ack) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    o_done <= 1'b1;
                    if (!wb.we) begin
                        o_valid  <= 1'b1;
                        o_wreg   <= tag_out[8:4];
                        o_result <= rd_lane;
                    end
                end
            end
        end
    end

    assign o_busy   = wb.cyc;
    assign o_rdbusy = wb.cyc && !wb.we && ((outstanding != '0) || wb.stb);
endmodule
